// File: rtl/ahb_mst_pkg.sv
// Shared types and encodings for the AHB-Lite command master.
package ahb_mst_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Widest address/data the command struct carries; the top uses the low bits.
  localparam int CMD_MAX_W = 64;

  typedef struct packed {
    logic                 write;
    logic [CMD_MAX_W-1:0] addr;
    logic [CMD_MAX_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ahb_mst_wdog.sv
// Wait-state watchdog for the AHB-Lite command master (used only with AHB_MST_TIMEOUT_EN).
module ahb_mst_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = 8'd0;
    else if (inc) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign expired = inc && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite initiator: command in, NONSEQ single transfer, response out.
// Optional wait-state timeout enabled by defining AHB_MST_TIMEOUT_EN.
module ahb_lite_cmd_master
  import ahb_mst_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              hsel_q, hsel_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tmo;

`ifdef AHB_MST_TIMEOUT_EN
  logic wd_clr, wd_inc;
  assign wd_clr = (state_q == IDLE) && cmd_valid;
  assign wd_inc = ((state_q == ADDR) || (state_q == DATA)) && !HREADY;

  ahb_mst_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (tmo)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_d                = '0;
        cmd_d.write          = cmd_write;
        cmd_d.addr[ADDR_W-1:0] = {cmd_addr[ADDR_W-1:2], 2'b00};
        cmd_d.wdata[DATA_W-1:0] = cmd_wdata;
        hsel_d               = 1'b1;
        htrans_d             = HTRANS_NONSEQ;
        state_d              = ADDR;
      end
      ADDR: if (HREADY) begin
        hsel_d   = 1'b0;
        htrans_d = HTRANS_IDLE;
        if (cmd_q.write) hwdata_d = cmd_q.wdata[DATA_W-1:0];
        state_d  = DATA;
      end
      DATA: if (HREADY) begin
        rsp_rdata_d = cmd_q.write ? '0 : HRDATA;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timeout abandons the transfer and reports an error response instead.
    if (tmo) begin
      hsel_d      = 1'b0;
      htrans_d    = HTRANS_IDLE;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Upper struct bits beyond ADDR_W/DATA_W are always zero.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q;

  assign cmd_ready = (state_q == IDLE) && !HRESET;
  assign HSEL      = hsel_q;
  assign HADDR     = cmd_q.addr[ADDR_W-1:0];
  assign HTRANS    = htrans_q;
  assign HWRITE    = cmd_q.write;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed self-checking bench for ahb_lite_cmd_master; the slave side is driven by hand.
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  int n_chk = 0;
  int n_err = 0;

  ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; HREADY = 1'b1; HRDATA = '0;

    // 1. reset
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) begin
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSEL, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hsize", HSIZE, 3'b010);
      end
    end
    HRESET = 1'b0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // 2. write, zero wait
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5300_0004; cmd_wdata = 32'h0000_00A5;
    tick(); cmd_valid = 1'b0;
    chk("wr_c1_htrans", HTRANS, 2'b10);
    chk("wr_c1_hsel", HSEL, 1'b1);
    chk("wr_c1_hwrite", HWRITE, 1'b1);
    chk("wr_c1_haddr", HADDR, 32'h5300_0004);
    chk("wr_c1_cmd_ready", cmd_ready, 1'b0);
    tick();
    chk("wr_c2_htrans", HTRANS, 2'b00);
    chk("wr_c2_hsel", HSEL, 1'b0);
    chk("wr_c2_hwdata", HWDATA, 32'hA5);
    chk("wr_c2_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("wr_c3_rsp_valid", rsp_valid, 1'b1);
    chk("wr_c3_rsp_err", rsp_err, 1'b0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    chk("wr_done_rsp_valid", rsp_valid, 1'b0);
    chk("wr_done_cmd_ready", cmd_ready, 1'b1);

    // 3. read with two data-phase wait states; rsp_ready already high
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5300_0000;
    tick(); cmd_valid = 1'b0;
    chk("rd_c1_htrans", HTRANS, 2'b10);
    chk("rd_c1_hwrite", HWRITE, 1'b0);
    tick(); HREADY = 1'b0;
    tick();
    chk("rd_c3_rsp_valid", rsp_valid, 1'b0);
    chk("rd_c3_htrans", HTRANS, 2'b00);
    tick(); HREADY = 1'b1; HRDATA = 32'h1234;
    chk("rd_c4_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("rd_c5_rsp_valid", rsp_valid, 1'b1);
    chk("rd_c5_rsp_rdata", rsp_rdata, 32'h1234);
    tick();
    chk("rd_c6_rsp_valid", rsp_valid, 1'b0);
    chk("rd_c6_cmd_ready", cmd_ready, 1'b1);

    // 4. response back-pressure with a second command waiting
    rsp_ready = 1'b0; HRDATA = 32'hDEAD_BEEF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5300_0008; cmd_wdata = 32'h55;
    tick();
    cmd_write = 1'b0; cmd_addr = 32'h5300_000F;
    tick(); tick();
    chk("bp_c3_rsp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_rsp_valid", rsp_valid, 1'b1);
      chk("bp_hold_rsp_rdata", rsp_rdata, 32'h0);
      chk("bp_hold_cmd_ready", cmd_ready, 1'b0);
      chk("bp_hold_htrans", HTRANS, 2'b00);
      if (i == 3) rsp_ready = 1'b1;
      else tick();
    end
    tick();
    chk("bp_idle_rsp_valid", rsp_valid, 1'b0);
    chk("bp_idle_cmd_ready", cmd_ready, 1'b1);
    rsp_ready = 1'b0; HRDATA = 32'hCAFE_F00D;
    tick(); cmd_valid = 1'b0;
    chk("bp2_htrans", HTRANS, 2'b10);
    chk("bp2_haddr_aligned", HADDR, 32'h5300_000C);
    chk("bp2_hwrite", HWRITE, 1'b0);
    tick(); tick();
    chk("bp2_rsp_valid", rsp_valid, 1'b1);
    chk("bp2_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    rsp_ready = 1'b1;
    tick();
    chk("bp2_done", rsp_valid, 1'b0);

    // 5. reset during data phase of a write
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5300_0010; cmd_wdata = 32'h77;
    tick(); cmd_valid = 1'b0;
    tick(); HREADY = 1'b0;
    chk("mid_pre_hwdata", HWDATA, 32'h77);
    #2 HRESET = 1'b1;
    #1;
    chk("mid_rst_htrans", HTRANS, 2'b00);
    chk("mid_rst_hwdata", HWDATA, 32'h0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    tick(); HRESET = 1'b0; HREADY = 1'b1; rsp_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (rsp_valid || HTRANS != 2'b00) seen++;
      end
      chk("mid_no_rsp", seen, 0);
    end
    chk("mid_cmd_ready", cmd_ready, 1'b1);

`ifdef AHB_MST_TIMEOUT_EN
    // 6. HREADY stuck low in the address phase
    rsp_ready = 1'b0; HREADY = 1'b0; HRDATA = 32'hFFFF_FFFF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5300_0020;
    tick(); cmd_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    chk("tmo_c16_htrans", HTRANS, 2'b10);
    chk("tmo_c16_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("tmo_htrans", HTRANS, 2'b00);
    chk("tmo_hsel", HSEL, 1'b0);
    chk("tmo_rsp_valid", rsp_valid, 1'b1);
    chk("tmo_rsp_err", rsp_err, 1'b1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1; HREADY = 1'b1;
    tick();
    chk("tmo_done", cmd_ready, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
